// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared constants, sample type and channel-width helper for the receiver arbiter
package receiver_pkg;

   localparam int DATA_W   = 17;
   localparam int TS_W     = 24;
   localparam int MAX_CH_W = 4;

   typedef struct packed {
      logic [MAX_CH_W-1:0] channel;
      logic [DATA_W-1:0]   data;
      logic [TS_W-1:0]     ts;
   } receiver_sample;

   // channel index width: max(1, clog2(n))
   function automatic int ch_w_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick over a request vector, starting after last_grant
module rr_priority_picker
   import receiver_pkg::*;
#(
   parameter int N    = 4,
   parameter int CH_W = ch_w_of(N)
) (
   input  logic [N-1:0]    req,
   input  logic [CH_W-1:0] last_grant,
   output logic            grant_valid,
   output logic [CH_W-1:0] grant_idx
);

   logic [CH_W-1:0] cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      // walk from farthest to nearest so the nearest requester after last_grant wins
      for (int k = N; k >= 1; k--) begin
         cand = CH_W'((int'(last_grant) + k) % N);
         if (req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/receiver_data_arbiter.sv
// rtl/receiver_data_arbiter.sv - per-channel sample buffer and round-robin serialiser; RECEIVER_DATA_ARBITER_OVERRUN_CNT_EN adds overrun_count
module receiver_data_arbiter
   import receiver_pkg::*;
#(
   parameter int N_RECEIVERS = 4,
   parameter int DATA_W      = receiver_pkg::DATA_W,
   parameter int TS_W        = receiver_pkg::TS_W,
   localparam int CH_W       = ch_w_of(N_RECEIVERS)
) (
   input  logic                        clk_96MHz,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [N_RECEIVERS-1:0]      data_availible,
   input  logic [N_RECEIVERS*DATA_W-1:0] decoded_data,
   input  logic [N_RECEIVERS*TS_W-1:0] ts_last_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CH_W-1:0]             out_channel,
   output logic [DATA_W-1:0]           out_data,
   output logic [TS_W-1:0]             out_ts,
   output logic [N_RECEIVERS-1:0]      overrun,
`ifdef RECEIVER_DATA_ARBITER_OVERRUN_CNT_EN
   output logic [N_RECEIVERS*8-1:0]    overrun_count,
`endif
   input  logic                        overrun_clear
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state_q, state_d;
   logic [N_RECEIVERS-1:0] pending;
   logic [N_RECEIVERS-1:0] capture;
   logic [N_RECEIVERS-1:0] granted;
   logic [N_RECEIVERS-1:0] ovr_event;
   logic [DATA_W-1:0]      hold_data [N_RECEIVERS];
   logic [TS_W-1:0]        hold_ts   [N_RECEIVERS];
   logic [CH_W-1:0]        last_grant;
   logic                   grant_valid;
   logic [CH_W-1:0]        grant_idx;
   logic                   grant;

   rr_priority_picker #(.N(N_RECEIVERS), .CH_W(CH_W)) u_picker (
      .req         (pending),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // a new grant is taken whenever the output register is empty or being emptied
   assign grant   = grant_valid & ((state_q == IDLE) | out_ready);
   assign capture = enable ? data_availible : '0;

   always_comb begin
      granted = '0;
      for (int i = 0; i < N_RECEIVERS; i++)
         granted[i] = grant && (grant_idx == CH_W'(i));
   end

   // a granted channel's old sample leaves this cycle, so recapturing it is not an overrun
   assign ovr_event = capture & pending & ~granted;

   always_ff @(posedge clk_96MHz or negedge reset) begin
      if (!reset) begin
         pending     <= '0;
         overrun     <= '0;
         last_grant  <= CH_W'(N_RECEIVERS - 1);
         out_channel <= '0;
         out_data    <= '0;
         out_ts      <= '0;
         for (int i = 0; i < N_RECEIVERS; i++) begin
            hold_data[i] <= '0;
            hold_ts[i]   <= '0;
         end
      end else begin
         pending <= capture | (pending & ~granted);
         overrun <= ovr_event | (overrun & ~{N_RECEIVERS{overrun_clear}});
         for (int i = 0; i < N_RECEIVERS; i++) begin
            if (capture[i]) begin
               hold_data[i] <= decoded_data[i*DATA_W +: DATA_W];
               hold_ts[i]   <= ts_last_data[i*TS_W +: TS_W];
            end
         end
         if (grant) begin
            out_channel <= grant_idx;
            out_data    <= hold_data[grant_idx];
            out_ts      <= hold_ts[grant_idx];
            last_grant  <= grant_idx;
         end
      end
   end

   always_ff @(posedge clk_96MHz or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      case (state_q)
         IDLE: if (grant) state_d = SEND;
         SEND: begin
            out_valid = 1'b1;
            if (out_ready) state_d = grant ? SEND : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef RECEIVER_DATA_ARBITER_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt [N_RECEIVERS];

   // saturating per-channel counters; an event in the clearing cycle counts as the first
   always_ff @(posedge clk_96MHz or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_RECEIVERS; i++) ovr_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_RECEIVERS; i++) begin
            if (ovr_event[i])
               ovr_cnt[i] <= overrun_clear ? 8'd1 : ((ovr_cnt[i] == 8'hFF) ? 8'hFF : ovr_cnt[i] + 8'd1);
            else if (overrun_clear)
               ovr_cnt[i] <= '0;
         end
      end
   end

   always_comb begin
      overrun_count = '0;
      for (int i = 0; i < N_RECEIVERS; i++) overrun_count[i*8 +: 8] = ovr_cnt[i];
   end
`endif

endmodule

// File: tb/tb_receiver_data_arbiter.sv
// tb/tb_receiver_data_arbiter.sv - directed and randomized bench for receiver_data_arbiter against a transaction-level model
module tb_receiver_data_arbiter;

   localparam int N  = 4;
   localparam int DW = 17;
   localparam int TW = 24;

   logic            clk_96MHz = 1'b0;
   logic            reset;
   logic            enable;
   logic [N-1:0]    data_availible;
   logic [N*DW-1:0] decoded_data;
   logic [N*TW-1:0] ts_last_data;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_channel;
   logic [DW-1:0]   out_data;
   logic [TW-1:0]   out_ts;
   logic [N-1:0]    overrun;
   logic            overrun_clear;
`ifdef RECEIVER_DATA_ARBITER_OVERRUN_CNT_EN
   logic [N*8-1:0]  overrun_count;
`endif

   always #5 clk_96MHz = ~clk_96MHz;

   receiver_data_arbiter dut (
      .clk_96MHz      (clk_96MHz),
      .reset          (reset),
      .enable         (enable),
      .data_availible (data_availible),
      .decoded_data   (decoded_data),
      .ts_last_data   (ts_last_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_channel    (out_channel),
      .out_data       (out_data),
      .out_ts         (out_ts),
      .overrun        (overrun),
`ifdef RECEIVER_DATA_ARBITER_OVERRUN_CNT_EN
      .overrun_count  (overrun_count),
`endif
      .overrun_clear  (overrun_clear)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model: one buffered sample per channel plus the payload on the output
   logic [DW-1:0] m_data [N];
   logic [TW-1:0] m_ts   [N];
   logic [N-1:0]  m_pend;
   logic [N-1:0]  m_ovr;
   int            m_cnt  [N];
   bit            m_valid;
   int            m_ch;
   int            m_last;
   logic [DW-1:0] m_odata;
   logic [TW-1:0] m_ots;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_ovr   = '0;
      m_valid = 1'b0;
      m_ch    = 0;
      m_last  = N - 1;
      m_odata = '0;
      m_ots   = '0;
      for (int i = 0; i < N; i++) begin
         m_data[i] = '0;
         m_ts[i]   = '0;
         m_cnt[i]  = 0;
      end
   endtask

   task automatic model_step();
      int g;
      bit ev;
      g = -1;
      if (!m_valid || out_ready) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (m_pend[idx] && g < 0) g = idx;
         end
      end
      if (g >= 0) begin
         m_valid   = 1'b1;
         m_ch      = g;
         m_odata   = m_data[g];
         m_ots     = m_ts[g];
         m_last    = g;
         m_pend[g] = 1'b0;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         ev = 1'b0;
         if (enable && data_availible[i]) begin
            ev        = m_pend[i];
            m_pend[i] = 1'b1;
            m_data[i] = decoded_data[i*DW +: DW];
            m_ts[i]   = ts_last_data[i*TW +: TW];
         end
         m_ovr[i] = ev | (m_ovr[i] & ~overrun_clear);
         if (ev)                 m_cnt[i] = overrun_clear ? 1 : ((m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1);
         else if (overrun_clear) m_cnt[i] = 0;
      end
   endtask

   task automatic compare();
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_channel", 64'(out_channel), 64'(m_ch));
      check("out_data", 64'(out_data), 64'(m_odata));
      check("out_ts", 64'(out_ts), 64'(m_ots));
      check("overrun", 64'(overrun), 64'(m_ovr));
`ifdef RECEIVER_DATA_ARBITER_OVERRUN_CNT_EN
      for (int i = 0; i < N; i++)
         check($sformatf("overrun_count%0d", i), 64'(overrun_count[i*8 +: 8]), 64'(m_cnt[i]));
`endif
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_96MHz);
      @(negedge clk_96MHz);
      compare();
   endtask

   task automatic set_ch(input int ch, input logic [DW-1:0] d, input logic [TW-1:0] t);
      decoded_data[ch*DW +: DW] = d;
      ts_last_data[ch*TW +: TW] = t;
   endtask

   task automatic randomize_payloads();
      for (int i = 0; i < N; i++) set_ch(i, DW'($urandom), TW'($urandom));
   endtask

   initial begin
      reset          = 1'b0;
      enable         = 1'b1;
      data_availible = '0;
      decoded_data   = '0;
      ts_last_data   = '0;
      out_ready      = 1'b1;
      overrun_clear  = 1'b0;
      model_reset();

      // reset state
      @(negedge clk_96MHz);
      @(negedge clk_96MHz);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      compare();
      reset = 1'b1;

      // single sample on ch2: valid two cycles after the pulse, for one cycle
      set_ch(2, 17'h1ABCD, 24'h123456);
      data_availible = 4'b0100;
      tick();
      check("lat_t1_valid", 64'(out_valid), 64'd0);
      data_availible = '0;
      tick();
      check("lat_t2_valid", 64'(out_valid), 64'd1);
      check("single_channel", 64'(out_channel), 64'd2);
      check("single_data", 64'(out_data), 64'h1ABCD);
      check("single_ts", 64'(out_ts), 64'h123456);
      tick();
      check("single_one_cycle", 64'(out_valid), 64'd0);

      // all channels at once, twice: back-to-back round-robin drain
      repeat (2) begin
         randomize_payloads();
         data_availible = 4'hF;
         tick();
         data_availible = '0;
         repeat (6) tick();
      end

      // backpressure: ch1 held while ch3 arrives, ch3 follows on accept
      out_ready = 1'b0;
      set_ch(1, 17'h0AAAA, 24'h111111);
      data_availible = 4'b0010;
      tick();
      data_availible = '0;
      tick();
      set_ch(3, 17'h13333, 24'h333333);
      data_availible = 4'b1000;
      tick();
      data_availible = '0;
      repeat (10) tick();
      check("bp_hold_channel", 64'(out_channel), 64'd1);
      check("bp_hold_data", 64'(out_data), 64'h0AAAA);
      out_ready = 1'b1;
      tick();
      check("bp_next_channel", 64'(out_channel), 64'd3);
      repeat (2) tick();

      // overrun on ch0 while output is stalled on another channel
      out_ready = 1'b0;
      data_availible = 4'b0010;
      tick();
      set_ch(0, 17'h00001, 24'h000001);
      data_availible = 4'b0001;
      tick();
      set_ch(0, 17'h00002, 24'h000002);
      tick();
      data_availible = '0;
      tick();
      check("ovr0_set", 64'(overrun[0]), 64'd1);
      out_ready = 1'b1;
      repeat (3) tick();
      check("ovr0_sticky", 64'(overrun[0]), 64'd1);
      overrun_clear = 1'b1;
      tick();
      overrun_clear = 1'b0;
      check("ovr0_cleared", 64'(overrun[0]), 64'd0);

      // grant and recapture of ch1 in the same cycle is not an overrun
      set_ch(1, 17'h01111, 24'h0000A1);
      data_availible = 4'b0010;
      tick();
      set_ch(1, 17'h02222, 24'h0000A2);
      tick();
      data_availible = '0;
      check("collide_no_ovr", 64'(overrun[1]), 64'd0);
      check("collide_old_out", 64'(out_data), 64'h01111);
      tick();
      check("collide_new_out", 64'(out_data), 64'h02222);
      tick();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         randomize_payloads();
         data_availible = N'($urandom) & N'($urandom);
         out_ready      = ($urandom_range(0, 3) != 0);
         enable         = ($urandom_range(0, 15) != 0);
         overrun_clear  = ($urandom_range(0, 19) == 0);
         tick();
      end
      data_availible = '0;
      enable         = 1'b1;
      overrun_clear  = 1'b0;

      // asynchronous reset while a payload is stalled on the output
      out_ready = 1'b0;
      data_availible = 4'b0100;
      tick();
      data_availible = '0;
      tick();
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      model_reset();
      @(negedge clk_96MHz);
      compare();
      reset = 1'b1;

      // enable low: pulses are ignored
      enable    = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         randomize_payloads();
         data_availible = N'($urandom);
         tick();
      end
      data_availible = '0;
      tick();
      check("disabled_no_out", 64'(out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
